// File: rtl/shift_sub_divider.sv
// Restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder, one trial subtract per clock.
// Latency: N cycles from the accepting edge (1 cycle for overflow or divide-by-zero).
// Backpressure: none; i_START is taken only when idle and is never queued.
module shift_sub_divider #(
    parameter int N = 4
) (
    input  logic             i_CLK,
    input  logic             i_RESET,
    input  logic             i_START,
    input  logic [2*N-1:0]   i_A,
    input  logic [N-1:0]     i_B,
    output logic [N-1:0]     o_Q,
    output logic [N-1:0]     o_R,
    output logic             o_BUSY,
    output logic             o_ERR,
    output logic             o_DONE
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    logic [2*N:0]    acc;
    logic [N-1:0]    d;
    logic [CW-1:0]   cnt;

    logic [2*N+1:0]  shifted;
    logic            fits;
    logic [N:0]      trial;
    logic [2*N:0]    acc_nxt;
    logic            start_err;

    // The shift keeps acc[2N] so the compare sees the full partial remainder.
    always_comb begin
        shifted = {acc, 1'b0};
        fits    = shifted[2*N+1:N] >= {2'b00, d};
        trial   = shifted[2*N:N] - {1'b0, d};
        acc_nxt = fits ? {trial, shifted[N-1:1], 1'b1} : shifted[2*N:0];
    end

    // A quotient wider than N bits is exactly the case high half >= divisor.
    assign start_err = (i_B == '0) || (i_A[2*N-1:N] >= i_B);

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state  <= IDLE;
            acc    <= '0;
            d      <= '0;
            cnt    <= '0;
            o_Q    <= '0;
            o_R    <= '0;
            o_ERR  <= 1'b0;
            o_BUSY <= 1'b0;
            o_DONE <= 1'b0;
        end else begin
            o_DONE <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_START) begin
                        acc <= {1'b0, i_A};
                        d   <= i_B;
                        cnt <= '0;
                        if (start_err) begin
                            state <= DONE;
                        end else begin
                            state  <= CALC;
                            o_BUSY <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        o_Q    <= acc_nxt[N-1:0];
                        o_R    <= acc_nxt[2*N-1:N];
                        o_ERR  <= 1'b0;
                        o_DONE <= 1'b1;
                        o_BUSY <= 1'b0;
                        state  <= IDLE;
                    end
                end
                DONE: begin
                    // Error result is published one edge after acceptance.
                    o_Q    <= '1;
                    o_R    <= '0;
                    o_ERR  <= 1'b1;
                    o_DONE <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider against an arithmetic reference model.
module tb_shift_sub_divider;

    localparam int N = 4;

    logic         i_CLK = 1'b0;
    logic         i_RESET = 1'b1;
    logic         i_START = 1'b0;
    logic [7:0]   i_A = '0;
    logic [3:0]   i_B = '0;
    logic [3:0]   o_Q;
    logic [3:0]   o_R;
    logic         o_BUSY;
    logic         o_ERR;
    logic         o_DONE;

    int errors = 0;
    int checks = 0;

    shift_sub_divider #(.N(N)) dut (
        .i_CLK   (i_CLK),
        .i_RESET (i_RESET),
        .i_START (i_START),
        .i_A     (i_A),
        .i_B     (i_B),
        .o_Q     (o_Q),
        .o_R     (o_R),
        .o_BUSY  (o_BUSY),
        .o_ERR   (o_ERR),
        .o_DONE  (o_DONE)
    );

    always #5 i_CLK = ~i_CLK;

    // Reference: plain integer division; error when the quotient cannot fit in 4 bits.
    function automatic void model(input int a, input int b,
                                  output logic [3:0] q, output logic [3:0] r, output logic err);
        if (b == 0 || (a / b) > 15) begin
            err = 1'b1; q = 4'hF; r = 4'h0;
        end else begin
            err = 1'b0; q = 4'(a / b); r = 4'(a % b);
        end
    endfunction

    // Called at a falling edge; returns at the falling edge where o_DONE is seen.
    task automatic do_op(input logic [7:0] a, input logic [3:0] b, output int lat, output int busy_n);
        i_START = 1'b1;
        i_A = a;
        i_B = b;
        @(posedge i_CLK);
        #1;
        i_START = 1'b0;
        i_A = 8'($urandom);
        i_B = 4'($urandom);
        lat = -1;
        busy_n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_CLK);
            if (o_BUSY) busy_n++;
            if (o_DONE) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({o_Q, o_R, o_ERR, o_BUSY, o_DONE} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {o_Q, o_R, o_ERR, o_BUSY, o_DONE});
        end
        repeat (2) @(negedge i_CLK);
        i_RESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_CLK);
            checks++;
            if (o_DONE !== 1'b0 || o_BUSY !== 1'b0) begin
                errors++;
                $display("FAIL reset_release: done=%b busy=%b expected 0 0", o_DONE, o_BUSY);
            end
        end
    endtask

    task automatic test_nominal();
        int lat, bn;
        do_op(8'd100, 4'd7, lat, bn);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL nominal_latency: got %0d expected 4", lat); end
        checks++;
        if (bn !== 4) begin errors++; $display("FAIL nominal_busy: got %0d expected 4", bn); end
        checks++;
        if (o_Q !== 4'd14 || o_R !== 4'd2 || o_ERR !== 1'b0) begin
            errors++;
            $display("FAIL nominal_result: got q=%0d r=%0d err=%b expected 14 2 0", o_Q, o_R, o_ERR);
        end
        @(negedge i_CLK);
        checks++;
        if (o_DONE !== 1'b0) begin errors++; $display("FAIL nominal_pulse_width: done=%b expected 0", o_DONE); end
        checks++;
        if (o_Q !== 4'd14 || o_R !== 4'd2) begin
            errors++;
            $display("FAIL nominal_hold: got q=%0d r=%0d expected 14 2", o_Q, o_R);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] ta [3] = '{8'd225, 8'd0, 8'd14};
        logic [3:0] tb [3] = '{4'd15, 4'd5, 4'd15};
        logic [3:0] tq [3] = '{4'd15, 4'd0, 4'd0};
        logic [3:0] tr [3] = '{4'd0, 4'd0, 4'd14};
        int lat, bn;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], lat, bn);
            checks++;
            if (lat !== 4 || o_Q !== tq[i] || o_R !== tr[i] || o_ERR !== 1'b0) begin
                errors++;
                $display("FAIL boundary_%0d_%0d: got lat=%0d q=%0d r=%0d err=%b expected 4 %0d %0d 0",
                         ta[i], tb[i], lat, o_Q, o_R, o_ERR, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [7:0] ta [3] = '{8'd255, 8'd37, 8'd0};
        logic [3:0] tb [3] = '{4'd15, 4'd0, 4'd0};
        int lat, bn;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], lat, bn);
            checks++;
            if (lat !== 1 || bn !== 0 || o_Q !== 4'hF || o_R !== 4'h0 || o_ERR !== 1'b1) begin
                errors++;
                $display("FAIL error_%0d_%0d: got lat=%0d busy=%0d q=%0d r=%0d err=%b expected 1 0 15 0 1",
                         ta[i], tb[i], lat, bn, o_Q, o_R, o_ERR);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        time t0, t1;
        logic [3:0] eq, er;
        logic ee;
        do_op(8'd100, 4'd7, lat, bn);
        t0 = $time;
        for (int i = 0; i < 6; i++) begin
            logic [7:0] a;
            logic [3:0] b;
            a = 8'($urandom);
            b = 4'($urandom_range(15, 1));
            if (a[7:4] >= b) a[7:4] = b - 4'd1;
            model(int'(a), int'(b), eq, er, ee);
            do_op(a, b, lat, bn);
            t1 = $time;
            checks++;
            if (t1 - t0 != 50 || o_Q !== eq || o_R !== er || o_ERR !== ee) begin
                errors++;
                $display("FAIL back_to_back_%0d: got dt=%0t q=%0d r=%0d err=%b expected 50 %0d %0d %b",
                         i, t1 - t0, o_Q, o_R, o_ERR, eq, er, ee);
            end
            t0 = t1;
        end
    endtask

    task automatic test_held_start();
        logic [7:0] av;
        logic [3:0] bv, eq, er;
        logic ee;
        int next_acc = 0;
        int done_edge = -100;
        for (int j = 0; j < 60; j++) begin
            if (j > 0) begin
                checks++;
                if (j - 1 == done_edge) begin
                    if (o_DONE !== 1'b1 || o_Q !== eq || o_R !== er || o_ERR !== ee) begin
                        errors++;
                        $display("FAIL held_start_result_%0d: got done=%b q=%0d r=%0d err=%b expected 1 %0d %0d %b",
                                 j, o_DONE, o_Q, o_R, o_ERR, eq, er, ee);
                    end
                end else if (o_DONE !== 1'b0) begin
                    errors++;
                    $display("FAIL held_start_spurious_%0d: done=%b expected 0", j, o_DONE);
                end
            end
            av = 8'($urandom);
            bv = 4'($urandom);
            i_START = 1'b1;
            i_A = av;
            i_B = bv;
            if (j == next_acc) begin
                model(int'(av), int'(bv), eq, er, ee);
                done_edge = j + (ee ? 1 : N);
                next_acc = done_edge + 1;
            end
            @(negedge i_CLK);
        end
        i_START = 1'b0;
        repeat (8) @(negedge i_CLK);
    endtask

    task automatic test_reset_mid();
        int lat, bn;
        i_START = 1'b1;
        i_A = 8'd100;
        i_B = 4'd7;
        @(posedge i_CLK);
        #1;
        i_START = 1'b0;
        @(posedge i_CLK);
        #2;
        i_RESET = 1'b1;
        #1;
        checks++;
        if ({o_Q, o_R, o_ERR, o_BUSY, o_DONE} !== 11'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b expected 0", {o_Q, o_R, o_ERR, o_BUSY, o_DONE});
        end
        @(negedge i_CLK);
        i_RESET = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_CLK);
            checks++;
            if (o_DONE !== 1'b0 || o_BUSY !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_done: done=%b busy=%b expected 0 0", o_DONE, o_BUSY);
            end
        end
        do_op(8'd200, 4'd13, lat, bn);
        checks++;
        if (lat !== 4 || o_Q !== 4'd15 || o_R !== 4'd5 || o_ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_next_op: got lat=%0d q=%0d r=%0d err=%b expected 4 15 5 0", lat, o_Q, o_R, o_ERR);
        end
    endtask

    task automatic test_random();
        int lat, bn;
        logic [7:0] a;
        logic [3:0] b, eq, er;
        logic ee;
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom);
            b = 4'($urandom);
            model(int'(a), int'(b), eq, er, ee);
            do_op(a, b, lat, bn);
            checks++;
            if (lat !== (ee ? 1 : N) || o_Q !== eq || o_R !== er || o_ERR !== ee) begin
                errors++;
                $display("FAIL random_%0d_%0d: got lat=%0d q=%0d r=%0d err=%b expected %0d %0d %0d %b",
                         a, b, lat, o_Q, o_R, o_ERR, ee ? 1 : N, eq, er, ee);
            end
        end
    endtask

    task automatic test_sweep();
        int lat, bn;
        logic [3:0] eq, er;
        logic ee;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                model(a, b, eq, er, ee);
                do_op(8'(a), 4'(b), lat, bn);
                checks++;
                if (o_ERR !== ee || lat !== (ee ? 1 : N)) begin
                    errors++;
                    $display("FAIL sweep_err_%0d_%0d: got err=%b lat=%0d expected %b %0d", a, b, o_ERR, lat, ee, ee ? 1 : N);
                end
                checks++;
                if (ee) begin
                    if (o_Q !== 4'hF || o_R !== 4'h0) begin
                        errors++;
                        $display("FAIL sweep_errval_%0d_%0d: got q=%0d r=%0d expected 15 0", a, b, o_Q, o_R);
                    end
                end else if (int'(o_Q) * b + int'(o_R) != a || int'(o_R) >= b || o_Q !== eq) begin
                    errors++;
                    $display("FAIL sweep_identity_%0d_%0d: got q=%0d r=%0d expected %0d %0d", a, b, o_Q, o_R, eq, er);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_boundaries();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_held_start();
        test_random();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
